// File: rtl/hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard/sequencing controller.
// The datapath side drives the stage fields and cache status; the controller drives the strobes.
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic [4:0]       idex_rt_out;
   logic             idex_MemRead;
   logic             ex_branch_taken;
   logic             ex_jump;
   logic             exmem_dREN;
   logic             exmem_dWEN;
   logic             memwb_halt;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             halt;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ihit, dhit, ifid_rs, ifid_rt, idex_rt_out, idex_MemRead,
             ex_branch_taken, ex_jump, exmem_dREN, exmem_dWEN, memwb_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, halt, stall_cycles, flush_count
   );

   modport slave (
      input  ihit, dhit, ifid_rs, ifid_rt, idex_rt_out, idex_MemRead,
             ex_branch_taken, ex_jump, exmem_dREN, exmem_dWEN, memwb_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, halt, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble/squash sequencing for the 5-stage datapath, with halt drain and event counters.
//   state  | meaning
//   RUN    | pipeline advancing; strobes follow the hazard priority
//   HALTED | halt reached WB; everything frozen until reset
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input logic    CLK,
   input logic    RST,
   hazard_if.slave hz
);
   typedef enum logic {RUN, HALTED} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic       dstall, lduse, redirect, istall;
   logic [4:0] en;      // {pc, ifid, idex, exmem, memwb}
   logic [1:0] flush;   // {ifid, idex}
   logic       inc_stall, inc_flush;

   assign dstall   = (hz.exmem_dREN | hz.exmem_dWEN) & ~hz.dhit;
   assign lduse    = hz.idex_MemRead && (hz.idex_rt_out != 5'd0) &&
                     ((hz.idex_rt_out == hz.ifid_rs) || (hz.idex_rt_out == hz.ifid_rt));
   assign redirect = hz.ex_branch_taken | hz.ex_jump;
   assign istall   = ~hz.ihit;

   always_comb begin
      en        = 5'b00000;
      flush     = 2'b00;
      inc_stall = 1'b0;
      inc_flush = 1'b0;
      state_d   = state_q;
      if (!RST && state_q == RUN) begin
         if (dstall) begin
            inc_stall = 1'b1;
         end else if (redirect) begin
            en        = 5'b11111;
            flush     = 2'b11;
            inc_flush = 1'b1;
         end else if (lduse) begin
            en        = 5'b00111;
            flush     = 2'b01;
            inc_stall = 1'b1;
         end else if (istall) begin
            en        = 5'b01111;
            flush     = 2'b10;
            inc_stall = 1'b1;
         end else begin
            en = 5'b11111;
         end
         // A pending halt waits out a data stall so the last store/load completes.
         if (hz.memwb_halt && !dstall) state_d = HALTED;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (inc_stall && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
      if (inc_flush && flush_q != {CNT_W{1'b1}}) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign hz.pc_en        = en[4];
   assign hz.ifid_en      = en[3];
   assign hz.idex_en      = en[2];
   assign hz.exmem_en     = en[1];
   assign hz.memwb_en     = en[0];
   assign hz.ifid_flush   = flush[1];
   assign hz.idex_flush   = flush[0];
   assign hz.halt         = (state_q == HALTED);
   assign hz.stall_cycles = stall_q;
   assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed strobes and counter values per step.
module tb_hazard_ctrl;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;

   hazard_if #(.CNT_W(16)) hz ();
   hazard_ctrl #(.CNT_W(16)) dut (.CLK(CLK), .RST(RST), .hz(hz));

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      hz.ihit = 1'b1; hz.dhit = 1'b1;
      hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd0; hz.idex_rt_out = 5'd0;
      hz.idex_MemRead = 1'b0; hz.ex_branch_taken = 1'b0; hz.ex_jump = 1'b0;
      hz.exmem_dREN = 1'b0; hz.exmem_dWEN = 1'b0; hz.memwb_halt = 1'b0;
   endtask

   // exp_en = {pc, ifid, idex, exmem, memwb}, exp_fl = {ifid_flush, idex_flush}
   task automatic chk_strobes(input string tag, input logic [4:0] exp_en, input logic [1:0] exp_fl);
      logic [6:0] obs;
      #1;
      obs = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
             hz.ifid_flush, hz.idex_flush};
      checks++;
      assert (obs === {exp_en, exp_fl}) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, {exp_en, exp_fl});
      end
   endtask

   task automatic chk_regs(input string tag, input logic exp_halt,
                           input logic [15:0] exp_stall, input logic [15:0] exp_flush);
      logic [32:0] obs;
      obs = {hz.halt, hz.stall_cycles, hz.flush_count};
      checks++;
      assert (obs === {exp_halt, exp_stall, exp_flush}) else begin
         errors++;
         $error("FAIL %s observed halt=%b stall=%h flush=%h expected halt=%b stall=%h flush=%h",
                tag, obs[32], obs[31:16], obs[15:0], exp_halt, exp_stall, exp_flush);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      idle_inputs();
      @(negedge CLK);
      RST = 1'b0;
      #2;
   endtask

   initial begin
      // Reset held with hazards present: strobes must stay low
      idle_inputs();
      hz.ex_branch_taken = 1'b1;
      hz.ihit = 1'b0;
      tick();
      chk_strobes("rst_strobes", 5'b00000, 2'b00);
      do_reset();
      chk_regs("rst_regs", 1'b0, 16'd0, 16'd0);
      chk_strobes("idle", 5'b11111, 2'b00);

      // Load-use: one bubble
      hz.idex_MemRead = 1'b1; hz.idex_rt_out = 5'd5; hz.ifid_rs = 5'd5;
      chk_strobes("lduse", 5'b00111, 2'b01);
      tick();
      chk_regs("lduse_cnt", 1'b0, 16'd1, 16'd0);
      hz.idex_MemRead = 1'b0;
      chk_strobes("lduse_after", 5'b11111, 2'b00);
      tick();
      chk_regs("lduse_once", 1'b0, 16'd1, 16'd0);
      hz.idex_MemRead = 1'b1; hz.idex_rt_out = 5'd0; hz.ifid_rs = 5'd0;
      chk_strobes("lduse_r0", 5'b11111, 2'b00);
      tick();
      chk_regs("lduse_r0_cnt", 1'b0, 16'd1, 16'd0);
      hz.idex_rt_out = 5'd7; hz.ifid_rs = 5'd3; hz.ifid_rt = 5'd7;
      chk_strobes("lduse_rt", 5'b00111, 2'b01);
      tick();
      chk_regs("lduse_rt_cnt", 1'b0, 16'd2, 16'd0);

      // Branch overrides load-use
      do_reset();
      hz.idex_MemRead = 1'b1; hz.idex_rt_out = 5'd5; hz.ifid_rs = 5'd5;
      hz.ex_branch_taken = 1'b1;
      chk_strobes("branch", 5'b11111, 2'b11);
      tick();
      chk_regs("branch_cnt", 1'b0, 16'd0, 16'd1);
      idle_inputs();
      hz.ex_jump = 1'b1; hz.ihit = 1'b0;
      chk_strobes("jump_istall", 5'b11111, 2'b11);
      tick();
      chk_regs("jump_cnt", 1'b0, 16'd0, 16'd2);

      // Data miss with redirect held
      do_reset();
      hz.exmem_dREN = 1'b1; hz.dhit = 1'b0; hz.ex_branch_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_strobes("dmiss_freeze", 5'b00000, 2'b00);
         tick();
      end
      chk_regs("dmiss_cnt", 1'b0, 16'd4, 16'd0);
      hz.dhit = 1'b1;
      chk_strobes("dmiss_release", 5'b11111, 2'b11);
      tick();
      chk_regs("dmiss_after", 1'b0, 16'd4, 16'd1);
      // Store miss freezes too
      idle_inputs();
      hz.exmem_dWEN = 1'b1; hz.dhit = 1'b0;
      chk_strobes("store_miss", 5'b00000, 2'b00);
      tick();
      chk_regs("store_cnt", 1'b0, 16'd5, 16'd1);

      // Fetch miss
      do_reset();
      hz.ihit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_strobes("imiss", 5'b01111, 2'b10);
         tick();
      end
      chk_regs("imiss_cnt", 1'b0, 16'd3, 16'd0);
      // Async reset mid-stall clears without a clock edge
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk_regs("async_rst", 1'b0, 16'd0, 16'd0);
      chk_strobes("async_rst_strobes", 5'b00000, 2'b00);
      do_reset();

      // Halt waits for the data stall to clear
      hz.exmem_dREN = 1'b1; hz.dhit = 1'b0; hz.memwb_halt = 1'b1;
      tick();
      tick();
      chk_regs("halt_wait", 1'b0, 16'd2, 16'd0);
      hz.dhit = 1'b1;
      chk_strobes("halt_release", 5'b11111, 2'b00);
      tick();
      chk_regs("halted", 1'b1, 16'd2, 16'd0);
      idle_inputs();
      hz.ihit = 1'b0; hz.ex_jump = 1'b1;
      chk_strobes("halted_strobes", 5'b00000, 2'b00);
      tick();
      tick();
      chk_regs("halted_frozen", 1'b1, 16'd2, 16'd0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk_regs("halt_rst", 1'b0, 16'd0, 16'd0);
      do_reset();

      // Halt together with fetch stall: stall applies, halt next edge
      hz.memwb_halt = 1'b1; hz.ihit = 1'b0;
      chk_strobes("halt_istall", 5'b01111, 2'b10);
      tick();
      chk_regs("halt_istall_regs", 1'b1, 16'd1, 16'd0);
      do_reset();

      // Saturation
      hz.ihit = 1'b0;
      for (int i = 0; i < 65534; i++) tick();
      chk_regs("sat_fffe", 1'b0, 16'hFFFE, 16'd0);
      for (int i = 0; i < 3; i++) tick();
      chk_regs("sat_hold", 1'b0, 16'hFFFF, 16'd0);
      chk_strobes("sat_strobes", 5'b01111, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. It takes the same ID/EX, EX/MEM and MEM/WB register-select and control fields that drive the forwarding unit, plus the cache hit signals and the EX branch outcome. From these it drives the per-stage enable and flush strobes that stall, bubble or squash the pipeline registers and the PC. It also owns the halt-drain state machine and two saturating performance counters.

## Interface
Parameters
- CNT_W, 16, width of the stall and flush counters

Ports
- CLK  in  1  core clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID
- idex_rt_out  in  5  rt of the instruction in EX
- idex_MemRead  in  1  instruction in EX is a load
- ex_branch_taken, ex_jump  in  1 each  control redirect resolved in EX
- exmem_dREN, exmem_dWEN  in  1 each  data memory request from the MEM stage
- memwb_halt  in  1  halt instruction has reached WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush  out  1 each  load a NOP/bubble on the next edge; a flush overrides the stage's enable
- halt  out  1  registered; processor halted
- stall_cycles, flush_count  out  CNT_W each  saturating event counters

## Operation
Derived terms (combinational)
- dstall = (exmem_dREN | exmem_dWEN) & ~dhit
- lduse = idex_MemRead & (idex_rt_out != 0) & (idex_rt_out == ifid_rs | idex_rt_out == ifid_rt)
- redirect = ex_branch_taken | ex_jump
- istall = ~ihit

FSM states: RUN and HALTED. Reset enters RUN.

Outputs in RUN are combinational from state and inputs. Priority, highest first:
1. dstall: all five enables = 0, both flushes = 0. The whole pipe freezes.
2. redirect: all enables = 1, ifid_flush = 1, idex_flush = 1. The PC loads the target. A redirect overrides lduse and istall because the younger instructions are squashed.
3. lduse: pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = memwb_en = 1. This inserts a one-cycle bubble.
4. istall: pc_en = 0, ifid_flush = 1, idex_en = exmem_en = memwb_en = 1. A bubble enters ID and the older instructions drain.
5. Otherwise: all enables = 1, flushes = 0.

RUN to HALTED transition
- Taken on the edge where memwb_halt = 1 and dstall = 0.
- With dstall = 1, the transition waits until the stall clears.

HALTED behaviour
- All enables = 0, flushes = 0, halt = 1.
- Counters are frozen.
- Only RST exits HALTED.

Counters
- stall_cycles increments in RUN on any cycle where priority 1, 3 or 4 is selected.
- flush_count increments in RUN on any cycle where priority 2 is selected.
- Both counters hold at all-ones; there is no wrap.

## Timing
- Reset values: state = RUN, halt = 0, stall_cycles = 0, flush_count = 0.
- While RST = 1, all enables = 0 and flushes = 0, regardless of other inputs.
- Enable and flush outputs are zero-latency (same cycle as their inputs). halt and the counters update on the edge following the qualifying cycle.
- lduse produces exactly one bubble. On the next cycle idex holds the bubble (MemRead = 0), so lduse deasserts without any extra state.
- dstall with lduse or redirect in the same cycle: freeze only. The lower-priority action applies on the first cycle with dhit = 1, with nothing lost or duplicated.
- memwb_halt together with redirect/lduse/istall: the priority output applies that cycle, and halt = 1 from the next edge.
- RST asserted mid-stall or in HALTED: returns to RUN asynchronously, and the counters clear.

## Test plan
- Load-use: idex_MemRead = 1, idex_rt_out = 5, ifid_rs = 5, ihit = 1 → exactly one cycle of pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cycles goes 0 → 1. Repeat with idex_rt_out = 0 → no stall.
- Branch: ex_branch_taken = 1 with lduse also true → ifid_flush = idex_flush = 1, pc_en = 1; flush_count = 1, stall_cycles unchanged.
- Data miss: exmem_dREN = 1, dhit = 0 for 4 cycles, with redirect held → all enables 0 for 4 cycles, then flush on the dhit cycle; stall_cycles = 4, flush_count = 1.
- Fetch miss: ihit = 0 for 3 cycles → ifid_flush = 1, pc_en = 0, downstream enables 1; stall_cycles = 3.
- Halt: memwb_halt = 1 during dstall → no halt until dhit. On the next edge halt = 1 and all enables 0 thereafter, counters frozen. Pulse RST → halt = 0, counters 0.
- Saturation: force stall_cycles to 0xFFFE, apply 3 istall cycles → count reads 0xFFFF and holds.
